// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 host transmitter shared state type, command constants and parity helper
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    ACK,
    WAIT_REL
  } ps2_state_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RSP_ACK     = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command byte handshake and status between a client and ps2_host_tx
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (output tx_data, tx_valid, input tx_ready, busy, done, err);
  modport slave  (input tx_data, tx_valid, output tx_ready, busy, done, err);
endinterface

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-flop synchronizer for PS2_CLK/PS2_DAT with PS2_CLK falling-edge detect
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  input  logic dat_in,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fe
);

  logic [1:0] clk_ff;
  logic [1:0] dat_ff;
  logic       clk_prev;

  // Idle bus is pulled high, so the flops reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_ff   <= 2'b11;
      dat_ff   <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], clk_in};
      dat_ff   <= {dat_ff[0], dat_in};
      clk_prev <= clk_ff[1];
    end
  end

  assign clk_sync = clk_ff[1];
  assign dat_sync = dat_ff[1];
  assign clk_fe   = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter (inhibit, request, frame, ACK check)
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 750_000
) (
  input  logic          clk,
  input  logic          rst,
  ps2_host_tx_if.slave  bus,
  input  logic          ps2_clk_in,
  input  logic          ps2_dat_in,
  output logic          ps2_clk_oe,
  output logic          ps2_dat_oe
);

  localparam int IW = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  if (CLK_HZ <= 0 || INHIBIT_CYC < 1 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("ps2_host_tx: invalid parameters");
  end

  logic clk_s, dat_s, clk_fe;

  ps2_line_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .clk_in   (ps2_clk_in),
    .dat_in   (ps2_dat_in),
    .clk_sync (clk_s),
    .dat_sync (dat_s),
    .clk_fe   (clk_fe)
  );

  ps2_state_e    state, state_n;
  logic [IW-1:0] inh_cnt, inh_cnt_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic [3:0]    bit_idx, bit_idx_n;
  logic [9:0]    frame, frame_n;
  logic          ready_q, ready_n, busy_q, busy_n, done_q, done_n, err_q, err_n;
  logic          clk_oe_q, clk_oe_n, dat_oe_q, dat_oe_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      inh_cnt  <= '0;
      to_cnt   <= '0;
      bit_idx  <= '0;
      frame    <= '1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
    end else begin
      state    <= state_n;
      inh_cnt  <= inh_cnt_n;
      to_cnt   <= to_cnt_n;
      bit_idx  <= bit_idx_n;
      frame    <= frame_n;
      ready_q  <= ready_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      err_q    <= err_n;
      clk_oe_q <= clk_oe_n;
      dat_oe_q <= dat_oe_n;
    end
  end

  always_comb begin
    state_n   = state;
    inh_cnt_n = inh_cnt;
    to_cnt_n  = to_cnt;
    bit_idx_n = bit_idx;
    frame_n   = frame;
    ready_n   = ready_q;
    busy_n    = busy_q;
    done_n    = 1'b0;
    err_n     = 1'b0;
    clk_oe_n  = clk_oe_q;
    dat_oe_n  = dat_oe_q;
    case (state)
      IDLE: begin
        ready_n  = 1'b1;
        busy_n   = 1'b0;
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        if (bus.tx_valid) begin
          // Frame after the start bit, shifted out LSB first: data, parity, stop.
          frame_n   = {1'b1, odd_parity(bus.tx_data), bus.tx_data};
          inh_cnt_n = '0;
          clk_oe_n  = 1'b1;
          ready_n   = 1'b0;
          busy_n    = 1'b1;
          state_n   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt == IW'(INHIBIT_CYC - 1)) begin
          clk_oe_n  = 1'b0;
          dat_oe_n  = 1'b1;
          to_cnt_n  = '0;
          bit_idx_n = '0;
          state_n   = SEND;
        end else begin
          inh_cnt_n = inh_cnt + IW'(1);
        end
      end
      SEND, ACK, WAIT_REL: begin
        to_cnt_n = to_cnt + TW'(1);
        if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b0;
          err_n    = 1'b1;
          ready_n  = 1'b1;
          busy_n   = 1'b0;
          state_n  = IDLE;
        end else if (state == SEND) begin
          if (clk_fe) begin
            dat_oe_n  = ~frame[0];
            frame_n   = {1'b1, frame[9:1]};
            bit_idx_n = bit_idx + 4'd1;
            if (bit_idx == 4'd9) state_n = ACK;
          end
        end else if (state == ACK) begin
          if (clk_fe) begin
            if (dat_s) begin
              err_n   = 1'b1;
              ready_n = 1'b1;
              busy_n  = 1'b0;
              state_n = IDLE;
            end else begin
              state_n = WAIT_REL;
            end
          end
        end else if (clk_s && dat_s) begin
          done_n  = 1'b1;
          ready_n = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.tx_ready = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign ps2_clk_oe   = clk_oe_q;
  assign ps2_dat_oe   = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with an open-drain PS/2 device model
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 50;
  localparam int TO   = 2000;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clk_oe, dat_oe;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic ps2_clk_line, ps2_dat_line;

  assign ps2_clk_line = ~(clk_oe | dev_clk_low);
  assign ps2_dat_line = ~(dat_oe | dev_dat_low);

  ps2_host_tx_if bus ();

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .ps2_clk_in (ps2_clk_line),
    .ps2_dat_in (ps2_dat_line),
    .ps2_clk_oe (clk_oe),
    .ps2_dat_oe (dat_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line image seen by the device: start, d0..d7, parity (1 when the byte has an even count of ones), stop.
  function automatic logic [10:0] expected_frame(input logic [7:0] b);
    int ones;
    logic [10:0] f;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      if (b[i]) ones++;
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Cycle monitor: invariants, pulse counts, inhibit length, timeout latency.
  int   done_cnt = 0, err_cnt = 0;
  int   inh_run = 0, inh_len = 0, since_inh = 0, err_delay = -1;
  logic prev_clk_oe = 1'b0;
  logic [1:0] err_lines = 2'b00;

  always @(negedge clk) begin
    if (!rst) begin
      inh_run     = 0;
      prev_clk_oe = 1'b0;
    end else begin
      check("ready_vs_busy", 32'(bus.tx_ready), 32'(!bus.busy));
      check("lines_released_when_idle", 32'(bus.busy ? 2'b00 : {clk_oe, dat_oe}), 32'd0);
      check("done_err_exclusive", 32'(bus.done & bus.err), 32'd0);
      check("oe_exclusive", 32'(clk_oe & dat_oe), 32'd0);
      if (clk_oe) inh_run++;
      else if (prev_clk_oe) begin
        inh_len   = inh_run;
        inh_run   = 0;
        since_inh = 0;
      end else since_inh++;
      prev_clk_oe = clk_oe;
      if (bus.done) done_cnt++;
      if (bus.err) begin
        err_cnt++;
        err_delay = since_inh;
        err_lines = {clk_oe, dat_oe};
      end
    end
  end

  // Device model: clocks a frame after seeing a request-to-send, samples while PS2_CLK is high.
  logic        dev_enable = 1'b1, dev_ack = 1'b1, dev_abort = 1'b0, dev_busy = 1'b0;
  logic [10:0] dev_frame = '0;
  int          dev_fe = 0, dev_frames = 0, fe1_lat = -1;

  task automatic dev_wait(input int n);
    for (int i = 0; i < n; i++) begin
      if (dev_abort) break;
      @(negedge clk);
    end
  endtask

  initial begin
    logic prev;
    int   n;
    forever begin
      @(negedge clk);
      if (dev_enable && rst && !ps2_clk_line && !dev_abort) begin
        dev_busy = 1'b1;
        n = 0;
        while (!(ps2_clk_line && !ps2_dat_line) && !dev_abort && n < 4*INH) begin
          @(negedge clk);
          n++;
        end
        if (ps2_clk_line && !ps2_dat_line && !dev_abort) begin
          dev_fe = 0;
          dev_wait(10);
          for (int k = 0; k < 11; k++) begin
            if (dev_abort) break;
            dev_frame[k] = ps2_dat_line;
            if (k == 10 && dev_ack) begin
              dev_dat_low = 1'b1;
              dev_wait(2);
            end
            prev        = dat_oe;
            dev_clk_low = 1'b1;
            dev_fe      = k + 1;
            for (int i = 0; i < HALF && !dev_abort; i++) begin
              @(negedge clk);
              if (k == 0 && fe1_lat < 0 && dat_oe !== prev) fe1_lat = i + 1;
            end
            dev_clk_low = 1'b0;
            dev_wait(HALF);
          end
          dev_dat_low = 1'b0;
          if (!dev_abort) dev_frames++;
        end
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        dev_busy    = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = b;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'($urandom_range(255));
    check("accept_sets_busy", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (!(bus.done || bus.err) && n < 4*TO) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4*TO) check(name, 32'd0, 32'd1);
  endtask

  task automatic clear_counts();
    done_cnt  = 0;
    err_cnt   = 0;
    err_delay = -1;
    err_lines = 2'b11;
  endtask

  initial begin
    int n, frames0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_clk_oe", 32'(clk_oe), 32'd0);
    check("rst_dat_oe", 32'(dat_oe), 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Nominal set-LEDs command with ACK
    clear_counts();
    fe1_lat = -1;
    frames0 = dev_frames;
    send(CMD_SET_LED);
    wait_end("nom_wait_timeout");
    repeat (5) @(negedge clk);
    check("nom_frame_model", 32'(dev_frame), 32'(expected_frame(CMD_SET_LED)));
    check("nom_frame_literal", 32'(dev_frame), 32'h7DA);
    check("nom_inhibit_len", 32'(inh_len), 32'(INH));
    check("nom_fe_to_dat_oe", 32'(fe1_lat), 32'd3);
    check("nom_done_pulses", 32'(done_cnt), 32'd1);
    check("nom_err_pulses", 32'(err_cnt), 32'd0);
    check("nom_frames", 32'(dev_frames - frames0), 32'd1);
    check("nom_tx_ready", 32'(bus.tx_ready), 32'd1);

    // Even-parity byte
    clear_counts();
    send(8'h00);
    wait_end("zero_wait_timeout");
    repeat (5) @(negedge clk);
    check("zero_frame_model", 32'(dev_frame), 32'(expected_frame(8'h00)));
    check("zero_frame_literal", 32'(dev_frame), 32'h600);
    check("zero_done_pulses", 32'(done_cnt), 32'd1);

    // Device omits the ACK
    clear_counts();
    dev_ack = 1'b0;
    send(CMD_ENABLE);
    wait_end("nak_wait_timeout");
    repeat (5) @(negedge clk);
    check("nak_frame_model", 32'(dev_frame), 32'(expected_frame(CMD_ENABLE)));
    check("nak_err_pulses", 32'(err_cnt), 32'd1);
    check("nak_done_pulses", 32'(done_cnt), 32'd0);
    check("nak_lines_at_err", 32'(err_lines), 32'd0);
    check("nak_tx_ready", 32'(bus.tx_ready), 32'd1);
    dev_ack = 1'b1;
    repeat (100) @(negedge clk);

    // Device never clocks
    clear_counts();
    dev_enable = 1'b0;
    send(CMD_RESET);
    wait_end("to_wait_timeout");
    repeat (5) @(negedge clk);
    check("to_err_delay", 32'(err_delay), 32'(TO));
    check("to_err_pulses", 32'(err_cnt), 32'd1);
    check("to_done_pulses", 32'(done_cnt), 32'd0);
    check("to_lines_at_err", 32'(err_lines), 32'd0);
    check("to_tx_ready", 32'(bus.tx_ready), 32'd1);
    dev_enable = 1'b1;

    // tx_valid held with changing data during a transfer
    clear_counts();
    frames0 = dev_frames;
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = CMD_SET_LED;
    @(negedge clk);
    bus.tx_data = 8'h55;
    check("hs_busy", 32'(bus.busy), 32'd1);
    n = 0;
    while (!(bus.done || bus.err) && n < 4*TO) begin
      @(negedge clk);
      if (n == 100) check("hs_ready_low", 32'(bus.tx_ready), 32'd0);
      n++;
    end
    bus.tx_valid = 1'b0;
    if (n >= 4*TO) check("hs_wait_timeout", 32'd0, 32'd1);
    repeat (200) @(negedge clk);
    check("hs_frame_model", 32'(dev_frame), 32'(expected_frame(CMD_SET_LED)));
    check("hs_frames", 32'(dev_frames - frames0), 32'd1);
    check("hs_done_pulses", 32'(done_cnt), 32'd1);
    check("hs_busy_after", 32'(bus.busy), 32'd0);

    // Reset in the middle of the data bits, then a clean send
    dev_fe = 0;
    send(8'hA5);
    n = 0;
    while (dev_fe < 5 && n < 4*TO) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached_bit4", 32'(dev_fe >= 5), 32'd1);
    check("mid_dat_oe_before", 32'(dat_oe), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_clk_oe", 32'(clk_oe), 32'd0);
    check("mid_dat_oe", 32'(dat_oe), 32'd0);
    check("mid_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("mid_busy", 32'(bus.busy), 32'd0);
    dev_abort = 1'b1;
    n = 0;
    while (dev_busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rst       = 1'b1;
    dev_abort = 1'b0;
    repeat (10) @(negedge clk);
    clear_counts();
    send(CMD_ENABLE);
    wait_end("post_wait_timeout");
    repeat (5) @(negedge clk);
    check("post_frame_model", 32'(dev_frame), 32'(expected_frame(CMD_ENABLE)));
    check("post_frame_literal", 32'(dev_frame), 32'h5E8);
    check("post_done_pulses", 32'(done_cnt), 32'd1);
    check("post_err_pulses", 32'(err_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
